ddr_lane_tester: RTL and testbench

- Parametrised DDR throughput pattern generator and loopback checker for the TT user-project wrapper.
- Each clock produces a rise/fall word pair for an external DDR output cell.
- Checks the rise/fall pair captured back from the pads, counts transferred pairs and word errors, and reports a run summary.
- Generalises the fixed 8-bit single-pattern test: parametric lane width, four pattern modes, saturating error counter, drain timeout.

---
 rtl/ddr_tt_pkg.sv | 52 +++++
 rtl/ddr_pattern_gen.sv | 80 ++++++++
 rtl/ddr_lane_tester.sv | 157 +++++++++++++++
 tb/tb_ddr_lane_tester.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_tt_pkg.sv
// ---------------------------------------------------------------------------
// ddr_tt_pkg
// Shared types and helpers for the DDR lane tester.
//   mode_e      : pattern selection (counter, PRBS7, walking-one, alternating)
//   state_e     : run-control states of the tester
//   PRBS7_SEED  : reload value of the PRBS7 register
//   prbs7_adv() : steps a PRBS7 register by nbits and returns the new register
//                 plus the produced bits, first bit in the MSB of the nbits
//                 window (bits[nbits-1]), right-aligned in a MAX_W field.
// ---------------------------------------------------------------------------
package ddr_tt_pkg;

    localparam int MAX_W = 16;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_PRBS7 = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_ALT   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [6:0]       state;
        logic [MAX_W-1:0] bits;
    } prbs7_res_t;

    // x^7 + x^6 + 1: the feedback bit is both the shifted-in bit and the
    // output bit, so a word is simply the last nbits feedback values.
    function automatic prbs7_res_t prbs7_adv(input logic [6:0] state, input int nbits);
        prbs7_res_t res;
        logic       fb;
        res.state = state;
        res.bits  = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < nbits) begin
                fb        = res.state[6] ^ res.state[5];
                res.state = {res.state[5:0], fb};
                res.bits  = {res.bits[MAX_W-2:0], fb};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ddr_pattern_gen.sv
// ---------------------------------------------------------------------------
// ddr_pattern_gen
// Produces the word pair g(2n) / g(2n+1) for the current pair index n.
// Used once as the transmit source and once as the receive reference.
//   clk, rst_n : clock and synchronous active-low reset
//   load       : restart the sequence at n = 0
//   adv        : step to the next pair (two words)
//   mode       : pattern selection
//   rise, fall : g(2n) and g(2n+1)
// ---------------------------------------------------------------------------
module ddr_pattern_gen
    import ddr_tt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    input  mode_e            mode,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] cnt_q;     // word index k = 2n, modulo 2^WIDTH
    logic [WIDTH-1:0] walk_q;    // one-hot at position 2n mod WIDTH
    logic [WIDTH-1:0] walk_1;    // one-hot at position 2n+1 mod WIDTH
    logic [WIDTH-1:0] alt_word;
    logic [6:0]       lfsr_q;
    prbs7_res_t       p_rise;
    prbs7_res_t       p_fall;
    logic             unused_bits;

    assign p_rise      = prbs7_adv(lfsr_q, WIDTH);
    assign p_fall      = prbs7_adv(p_rise.state, WIDTH);
    assign walk_1      = {walk_q[WIDTH-2:0], walk_q[WIDTH-1]};
    assign unused_bits = ^{p_rise.bits, p_fall.bits};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            cnt_q  <= '0;
            walk_q <= WIDTH'(1);
            lfsr_q <= PRBS7_SEED;
        end else if (adv) begin
            cnt_q  <= cnt_q + WIDTH'(2);
            walk_q <= {walk_1[WIDTH-2:0], walk_1[WIDTH-1]};
            lfsr_q <= p_fall.state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        alt_word = '0;
        for (int i = 0; i < WIDTH; i += 2) alt_word[i] = 1'b1;
        rise = '0;
        fall = '0;
        case (mode)
            MODE_CNT: begin
                rise = cnt_q;
                fall = cnt_q + WIDTH'(1);
            end
            MODE_PRBS7: begin
                rise = p_rise.bits[WIDTH-1:0];
                fall = p_fall.bits[WIDTH-1:0];
            end
            MODE_WALK: begin
                rise = walk_q;
                fall = walk_1;
            end
            default: begin
                rise = alt_word;
                fall = ~alt_word;
            end
        endcase
    end

endmodule

// File: rtl/ddr_lane_tester.sv
// ---------------------------------------------------------------------------
// ddr_lane_tester
// DDR throughput pattern generator and loopback checker.
//   clk, rst_n          : clock, synchronous active-low reset
//   ena                 : clock enable; low freezes everything
//   start, mode, len    : run request (accepted in IDLE or DONE only)
//   tx_rise/fall/valid  : pair towards the DDR output cell
//   rx_rise/fall/valid  : pair captured back from the pads
//   busy, done          : RUN|DRAIN, DONE
//   timeout, overrun    : sticky drain timeout / surplus rx pair
//   err_count, err_bits : saturating word-error count, sticky bit-error OR
//   pair_count          : rx pairs checked
// ---------------------------------------------------------------------------
module ddr_lane_tester
    import ddr_tt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int ERR_W = 12,
    parameter int TO_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] len,
    output logic [WIDTH-1:0] tx_rise,
    output logic [WIDTH-1:0] tx_fall,
    output logic             tx_valid,
    input  logic [WIDTH-1:0] rx_rise,
    input  logic [WIDTH-1:0] rx_fall,
    input  logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             overrun,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] err_bits,
    output logic [CNT_W-1:0] pair_count
);

    state_e           state_q, state_d;
    mode_e            mode_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [WIDTH-1:0] gen_rise, gen_fall, ref_rise, ref_fall;
    logic             start_ok, active, rx_take, rx_over;
    logic             tx_last, drain_done, drain_expired;
    logic [1:0]       word_errs;
    logic [ERR_W:0]   err_sum;

    assign start_ok      = ena && start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign active        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign rx_take       = ena && rx_valid && active && (pair_count != len_q);
    assign rx_over       = ena && rx_valid && active && (pair_count == len_q);
    assign tx_last       = (tx_cnt_q + CNT_W'(1)) == len_q;
    assign drain_done    = pair_count == len_q;
    assign drain_expired = &to_cnt_q;

    ddr_pattern_gen #(.WIDTH(WIDTH)) u_tx_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok),
        .adv   (ena && state_q == ST_RUN),
        .mode  (mode_q),
        .rise  (gen_rise),
        .fall  (gen_fall)
    );

    // Reference advances only on accepted rx pairs, so loopback latency
    // does not matter.
    ddr_pattern_gen #(.WIDTH(WIDTH)) u_rx_ref (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok),
        .adv   (rx_take),
        .mode  (mode_q),
        .rise  (ref_rise),
        .fall  (ref_fall)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) state_d = (len == '0) ? ST_DONE : ST_RUN;
                ST_RUN:           if (tx_last) state_d = ST_DRAIN;
                default:          if (drain_done || drain_expired) state_d = ST_DONE;
            endcase
        end
    end

    // Outputs decoded from state; tx words are zero outside RUN.
    always_comb begin
        tx_valid = (state_q == ST_RUN);
        busy     = active;
        done     = (state_q == ST_DONE);
        tx_rise  = tx_valid ? gen_rise : '0;
        tx_fall  = tx_valid ? gen_fall : '0;
    end

    // Two words per pair, so the error count can climb by two per cycle.
    always_comb begin
        word_errs = {1'b0, rx_rise != ref_rise} + {1'b0, rx_fall != ref_fall};
        err_sum   = {1'b0, err_count} + (ERR_W + 1)'(word_errs);
    end

    // NOTE: only control and result registers need a reset; there is no
    // storage array here, so everything is cleared and the summary is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_CNT;
            len_q      <= '0;
            tx_cnt_q   <= '0;
            to_cnt_q   <= '0;
            pair_count <= '0;
            err_count  <= '0;
            err_bits   <= '0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
        end else if (ena) begin
            if (start_ok) begin
                mode_q     <= mode_e'(mode);
                len_q      <= len;
                tx_cnt_q   <= '0;
                to_cnt_q   <= '0;
                pair_count <= '0;
                err_count  <= '0;
                err_bits   <= '0;
                timeout    <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                if (state_q == ST_RUN) tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                if (state_q == ST_DRAIN) begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    if (!drain_done && drain_expired) timeout <= 1'b1;
                end
                if (rx_take) begin
                    pair_count <= pair_count + CNT_W'(1);
                    err_count  <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
                    err_bits   <= err_bits | (rx_rise ^ ref_rise) | (rx_fall ^ ref_fall);
                end
                if (rx_over) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_lane_tester.sv
// ---------------------------------------------------------------------------
// tb_ddr_lane_tester
// Directed bench for ddr_lane_tester (WIDTH=8, ERR_W=4, TO_W=4).
// ---------------------------------------------------------------------------
module tb_ddr_lane_tester;

    logic        clk = 1'b0;
    logic        rst_n, ena, start, rx_valid;
    logic [1:0]  mode;
    logic [15:0] len;
    logic [7:0]  tx_rise, tx_fall, rx_rise, rx_fall, err_bits;
    logic        tx_valid, busy, done, timeout, overrun;
    logic [3:0]  err_count;
    logic [15:0] pair_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] log_r [0:31];
    logic [7:0] log_f [0:31];
    int         n_log, drain_at, done_at;

    logic       pv [0:7];
    logic [7:0] pr [0:7];
    logic [7:0] pf [0:7];

    ddr_lane_tester #(.WIDTH(8), .CNT_W(16), .ERR_W(4), .TO_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .mode       (mode),
        .len        (len),
        .tx_rise    (tx_rise),
        .tx_fall    (tx_fall),
        .tx_valid   (tx_valid),
        .rx_rise    (rx_rise),
        .rx_fall    (rx_fall),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .overrun    (overrun),
        .err_count  (err_count),
        .err_bits   (err_bits),
        .pair_count (pair_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start a run and loop the tx pairs back with a fixed latency until DONE
    // or a 100-cycle budget runs out.
    task automatic run(input logic [1:0] m, input logic [15:0] l, input int lat,
                       input bit inv, input int flip_pair, input logic [7:0] flip_mask,
                       input bit drive_rx, input bit extra);
        int rx_n;
        int cyc;
        for (int i = 0; i < 8; i++) begin
            pv[i] = 1'b0; pr[i] = '0; pf[i] = '0;
        end
        n_log = 0; drain_at = -1; rx_n = 0;
        mode = m; len = l; start = 1'b1;
        tick();
        start = 1'b0;
        for (cyc = 0; cyc < 100 && !done; cyc++) begin
            if (tx_valid && n_log < 32) begin
                log_r[n_log] = tx_rise;
                log_f[n_log] = tx_fall;
                n_log++;
            end
            if (busy && !tx_valid && drain_at < 0) drain_at = cyc;
            for (int i = 7; i > 0; i--) begin
                pv[i] = pv[i-1]; pr[i] = pr[i-1]; pf[i] = pf[i-1];
            end
            pv[0] = tx_valid; pr[0] = tx_rise; pf[0] = tx_fall;
            rx_valid = drive_rx && pv[lat];
            rx_rise  = inv ? ~pr[lat] : pr[lat];
            rx_fall  = inv ? ~pf[lat] : pf[lat];
            if (rx_valid) begin
                if (rx_n == flip_pair) rx_fall = rx_fall ^ flip_mask;
                rx_n++;
            end else if (extra && busy && !tx_valid) begin
                rx_valid = 1'b1; rx_rise = 8'h5A; rx_fall = 8'hA5;
            end
            tick();
        end
        done_at  = cyc;
        rx_valid = 1'b0;
        check("run_reached_done", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] walk_r [0:4];
        logic [7:0] walk_f [0:4];
        walk_r = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h01};
        walk_f = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h02};

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; mode = 2'd0; len = '0;
        rx_valid = 1'b0; rx_rise = '0; rx_fall = '0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_rise", tx_rise, 0);
        check("rst_err", err_count, 0);
        check("rst_pairs", pair_count, 0);
        rst_n = 1'b1;
        tick();

        // Counter, latency 3.
        run(2'd0, 16'd4, 3, 1'b0, -1, 8'h00, 1'b1, 1'b0);
        check("cnt_nlog", n_log, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cnt_rise%0d", i), log_r[i], 2 * i);
            check($sformatf("cnt_fall%0d", i), log_f[i], 2 * i + 1);
        end
        check("cnt_err", err_count, 0);
        check("cnt_pairs", pair_count, 4);
        check("cnt_timeout", timeout, 0);
        check("cnt_overrun", overrun, 0);
        check("cnt_tx_valid_done", tx_valid, 0);

        // Walking-one, zero latency.
        run(2'd2, 16'd5, 0, 1'b0, -1, 8'h00, 1'b1, 1'b0);
        check("walk_nlog", n_log, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("walk_rise%0d", i), log_r[i], walk_r[i]);
            check($sformatf("walk_fall%0d", i), log_f[i], walk_f[i]);
        end
        check("walk_err", err_count, 0);
        check("walk_pairs", pair_count, 5);

        // PRBS7 with bit 3 of the second rx_fall flipped.
        run(2'd1, 16'd8, 2, 1'b0, 1, 8'h08, 1'b1, 1'b0);
        check("prbs_rise0", log_r[0], 8'h02);
        check("prbs_fall0", log_f[0], 8'h0C);
        check("prbs_rise1", log_r[1], 8'h28);
        check("prbs_fall1", log_f[1], 8'hF2);
        check("prbs_err", err_count, 1);
        check("prbs_bits", err_bits, 8'h08);
        check("prbs_pairs", pair_count, 8);

        // Alternating, inverted loopback: 20 bad words saturate at 15.
        run(2'd3, 16'd10, 1, 1'b1, -1, 8'h00, 1'b1, 1'b0);
        check("alt_rise0", log_r[0], 8'h55);
        check("alt_fall0", log_f[0], 8'hAA);
        check("alt_err_sat", err_count, 15);
        check("alt_bits", err_bits, 8'hFF);
        check("alt_pairs", pair_count, 10);

        // No rx at all: drain times out after 16 cycles.
        run(2'd0, 16'd3, 0, 1'b0, -1, 8'h00, 1'b0, 1'b0);
        check("to_drain_at", drain_at, 3);
        check("to_drain_len", done_at - drain_at, 16);
        check("to_timeout", timeout, 1);
        check("to_pairs", pair_count, 0);
        rx_valid = 1'b1; rx_rise = 8'h11; rx_fall = 8'h22;
        tick(); tick();
        rx_valid = 1'b0;
        check("to_no_overrun", overrun, 0);
        check("to_still_done", done, 1);
        check("to_pairs_held", pair_count, 0);

        // Enable freeze, then reset mid-run at pair 2.
        mode = 2'd0; len = 16'd6; start = 1'b1;
        tick();
        start = 1'b0;
        check("frz_rise0", tx_rise, 8'h00);
        rx_valid = 1'b1; rx_rise = ~tx_rise; rx_fall = ~tx_fall;
        ena = 1'b0;
        tick(); tick();
        check("frz_rise_held", tx_rise, 8'h00);
        check("frz_valid_held", tx_valid, 1);
        check("frz_pairs_held", pair_count, 0);
        ena = 1'b1;
        tick();
        check("frz_rise1", tx_rise, 8'h02);
        check("frz_err1", err_count, 2);
        rx_rise = ~tx_rise; rx_fall = ~tx_fall;
        tick();
        check("frz_rise2", tx_rise, 8'h04);
        check("frz_err2", err_count, 4);
        rst_n = 1'b0; rx_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_tx_valid", tx_valid, 0);
        check("mrst_tx_rise", tx_rise, 0);
        check("mrst_tx_fall", tx_fall, 0);
        check("mrst_err", err_count, 0);
        check("mrst_bits", err_bits, 0);
        check("mrst_pairs", pair_count, 0);
        check("mrst_flags", {timeout, overrun}, 0);
        tick();
        check("mrst_idle_hold", busy, 0);

        run(2'd0, 16'd2, 0, 1'b0, -1, 8'h00, 1'b1, 1'b0);
        check("rerun_rise0", log_r[0], 8'h00);
        check("rerun_fall1", log_f[1], 8'h03);
        check("rerun_err", err_count, 0);
        check("rerun_pairs", pair_count, 2);

        // Surplus rx pair during drain sets overrun without counting.
        run(2'd0, 16'd2, 0, 1'b0, -1, 8'h00, 1'b1, 1'b1);
        check("ovr_flag", overrun, 1);
        check("ovr_err", err_count, 0);
        check("ovr_pairs", pair_count, 2);

        // len == 0 goes straight to DONE with cleared results.
        run(2'd0, 16'd0, 0, 1'b0, -1, 8'h00, 1'b1, 1'b0);
        check("len0_done_at", done_at, 0);
        check("len0_overrun", overrun, 0);
        check("len0_pairs", pair_count, 0);

        // start while ena is low is ignored.
        ena = 1'b0; start = 1'b1; len = 16'd5;
        tick(); tick();
        start = 1'b0; ena = 1'b1;
        tick();
        check("ena_start_ignored_done", done, 1);
        check("ena_start_ignored_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
